// File: rtl/button_debounce_if.sv
// button_debounce_if
//   Groups the pin-side and CPU-side signals of the button conditioning stage.
//   This bus has no valid/ready handshake. The master drives btn_raw and
//   clr_sticky. The slave (button_debounce) drives the conditioned outputs,
//   and each output is valid on every clock.
//
//   btn_raw     : raw asynchronous button pins (bit 7 = morse_left ... bit 0 = button_bigButton)
//   clr_sticky  : per-bit clear strobe for btn_sticky, sampled on clk
//   btn_level   : debounced level, 1 = pressed (after polarity correction)
//   btn_press   : one-cycle pulse when btn_level goes 0->1
//   btn_release : one-cycle pulse when btn_level goes 1->0
//   btn_sticky  : set on press, held until cleared through clr_sticky
interface button_debounce_if #(
  parameter int N = 8
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] clr_sticky;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_sticky;

  modport master (
    output btn_raw,
    output clr_sticky,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_sticky
  );

  modport slave (
    input  btn_raw,
    input  clr_sticky,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_sticky
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce
//   Conditions N raw button pins for the memory-mapped button read port.
//   Each channel passes through a two-FF synchroniser and an optional
//   polarity inversion. A per-channel stability counter then debounces it.
//   The outputs are a clean level, one-cycle press/release pulses and sticky
//   press flags that the CPU clears.
//
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : button_debounce_if slave modport (btn_raw, clr_sticky in;
//           btn_level, btn_press, btn_release, btn_sticky out)
//
//   A changed input must be seen for DEBOUNCE_CYCLES consecutive cycles
//   before btn_level follows it. The valid range is 2 .. 2^CNT_WIDTH-1.
module button_debounce #(
  parameter int           N               = 8,
  parameter int           CNT_WIDTH       = 16,
  parameter int           DEBOUNCE_CYCLES = 50000,
  parameter logic [N-1:0] ACTIVE_LOW      = {N{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  button_debounce_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]         sync1;
  logic [N-1:0]         sync2;
  logic [N-1:0]         s;        // synchronised, polarity-corrected: 1 = pressed
  logic [N-1:0]         accept;   // channel's level flips at this edge
  logic [N-1:0]         level_q;
  logic [N-1:0]         press_q;
  logic [N-1:0]         rel_q;
  logic [N-1:0]         sticky_q;
  logic [CNT_WIDTH-1:0] cnt [N];

  // The synchroniser resets to the idle pin value. After reset release, s
  // therefore matches level_q, and no spurious count or press can start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ ACTIVE_LOW;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (s[i] != level_q[i]) && (cnt[i] == LAST_CNT);
    end
  end

  // Any cycle in which s agrees with the level restarts the count. The
  // counter also restarts on acceptance, so it never passes LAST_CNT.
  for (genvar g = 0; g < N; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[g] <= '0;
      end else if ((s[g] == level_q[g]) || accept[g]) begin
        cnt[g] <= '0;
      end else begin
        cnt[g] <= cnt[g] + 1'b1;
      end
    end
  end

  // The pulses are registered on the flip edge, so each lasts exactly one
  // cycle. On the flip edge, accept & s marks a 0->1 transition and
  // accept & ~s marks a 1->0 transition. The set term is ORed after the
  // clear mask, so a press wins over a simultaneous clr_sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      sticky_q <= '0;
    end else begin
      level_q  <= level_q ^ accept;
      press_q  <= accept & s;
      rel_q    <= accept & ~s;
      sticky_q <= (accept & s) | (sticky_q & ~bus.clr_sticky);
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = rel_q;
  assign bus.btn_sticky  = sticky_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  button_debounce_if #(.N(N)) bus ();

  button_debounce #(
    .N              (N),
    .CNT_WIDTH      (16),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (8'hFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Move to just after the next rising edge, where outputs are stable and
  // new inputs can be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n          = 1'b0;
    bus.btn_raw    = 8'hFF;
    bus.clr_sticky = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_sticky} !== 32'h0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: level=%h press=%h release=%h sticky=%h, required all 00",
                 k, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_sticky);
      end
    end
  endtask

  // Press on channel 0. The pin drops right after edge 0, and the level
  // flips at edge 6.
  task automatic test_press();
    logic exp_lvl, exp_p;
    bus.btn_raw[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_lvl = (k >= 6);
      exp_p   = (k == 6);
      tests++;
      if ({bus.btn_level[0], bus.btn_press[0], bus.btn_release[0]} !== {exp_lvl, exp_p, 1'b0}) begin
        fails++;
        $display("FAIL press_ch0 edge %0d: level/press/release=%b%b%b, required %b%b0",
                 k, bus.btn_level[0], bus.btn_press[0], bus.btn_release[0], exp_lvl, exp_p);
      end
    end
    tests++;
    if ({bus.btn_level, bus.btn_sticky} !== {8'h01, 8'h01}) begin
      fails++;
      $display("FAIL press_ch0_vectors: level=%h sticky=%h, required 01 01", bus.btn_level, bus.btn_sticky);
    end
  endtask

  // Channel 3 is held low for 3 cycles, which is too short. It is then held
  // low long enough to be accepted.
  task automatic test_glitch();
    step();
    bus.btn_raw[3] = 1'b0;
    repeat (3) step();
    bus.btn_raw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++;
      if ({bus.btn_level[3], bus.btn_press[3], bus.btn_release[3], bus.btn_sticky[3]} !== 4'b0000) begin
        fails++;
        $display("FAIL glitch_reject_ch3 cycle %0d: level/press/release/sticky=%b%b%b%b, required 0000",
                 k, bus.btn_level[3], bus.btn_press[3], bus.btn_release[3], bus.btn_sticky[3]);
      end
    end
    bus.btn_raw[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic exp_lvl, exp_p;
      step();
      exp_lvl = (k >= 6);
      exp_p   = (k == 6);
      tests++;
      if ({bus.btn_level[3], bus.btn_press[3]} !== {exp_lvl, exp_p}) begin
        fails++;
        $display("FAIL glitch_accept_ch3 edge %0d: level/press=%b%b, required %b%b",
                 k, bus.btn_level[3], bus.btn_press[3], exp_lvl, exp_p);
      end
    end
    tests++;
    if ({bus.btn_level, bus.btn_sticky} !== {8'h09, 8'h09}) begin
      fails++;
      $display("FAIL glitch_vectors: level=%h sticky=%h, required 09 09", bus.btn_level, bus.btn_sticky);
    end
  endtask

  // Channel 7 bounces 0,1,0,1 every 2 cycles and then holds 0 from edge 8.
  // The single press lands at edge 14.
  task automatic test_bounce();
    int presses;
    presses = 0;
    for (int k = 0; k <= 22; k++) begin
      if (k == 0 || k == 4 || k == 8) bus.btn_raw[7] = 1'b0;
      if (k == 2 || k == 6)           bus.btn_raw[7] = 1'b1;
      step();
      if (bus.btn_press[7] === 1'b1) presses++;
      tests++;
      if (bus.btn_press[7] !== ((k + 1) == 14)) begin
        fails++;
        $display("FAIL bounce_press_ch7 edge %0d: press=%b, required %b",
                 k + 1, bus.btn_press[7], ((k + 1) == 14));
      end
    end
    tests++;
    if (presses != 1) begin
      fails++;
      $display("FAIL bounce_press_count: %0d presses, required 1", presses);
    end
    tests++;
    if ({bus.btn_level, bus.btn_sticky} !== {8'h89, 8'h89}) begin
      fails++;
      $display("FAIL bounce_vectors: level=%h sticky=%h, required 89 89", bus.btn_level, bus.btn_sticky);
    end
  endtask

  // Channel 0 pin returns high. The release pulse comes at edge 6, and the
  // sticky flag stays set.
  task automatic test_release();
    bus.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic exp_lvl, exp_r;
      step();
      exp_lvl = (k < 6);
      exp_r   = (k == 6);
      tests++;
      if ({bus.btn_level[0], bus.btn_press[0], bus.btn_release[0]} !== {exp_lvl, 1'b0, exp_r}) begin
        fails++;
        $display("FAIL release_ch0 edge %0d: level/press/release=%b%b%b, required %b0%b",
                 k, bus.btn_level[0], bus.btn_press[0], bus.btn_release[0], exp_lvl, exp_r);
      end
    end
    tests++;
    if ({bus.btn_level, bus.btn_sticky} !== {8'h88, 8'h89}) begin
      fails++;
      $display("FAIL release_vectors: level=%h sticky=%h, required 88 89", bus.btn_level, bus.btn_sticky);
    end
  endtask

  task automatic test_sticky_clear();
    // A clear with no set clears channel 0 only.
    bus.clr_sticky = 8'h01;
    step();
    bus.clr_sticky = 8'h00;
    tests++;
    if (bus.btn_sticky !== 8'h88) begin
      fails++;
      $display("FAIL sticky_clear_ch0: sticky=%h, required 88", bus.btn_sticky);
    end
    // A new press, with a clear on the same edge: the set wins.
    bus.btn_raw[0] = 1'b0;
    repeat (5) step();
    bus.clr_sticky = 8'h01;
    step();
    bus.clr_sticky = 8'h00;
    tests++;
    if ({bus.btn_press[0], bus.btn_sticky} !== {1'b1, 8'h89}) begin
      fails++;
      $display("FAIL sticky_set_wins: press0=%b sticky=%h, required 1 89", bus.btn_press[0], bus.btn_sticky);
    end
    // A clear alone drops the flag.
    step();
    bus.clr_sticky = 8'h01;
    step();
    bus.clr_sticky = 8'h00;
    tests++;
    if (bus.btn_sticky !== 8'h88) begin
      fails++;
      $display("FAIL sticky_clear_again: sticky=%h, required 88", bus.btn_sticky);
    end
    // A clear on bit 7 touches only channel 7.
    bus.clr_sticky = 8'h80;
    step();
    bus.clr_sticky = 8'h00;
    tests++;
    if ({bus.btn_level, bus.btn_sticky} !== {8'h89, 8'h08}) begin
      fails++;
      $display("FAIL sticky_clear_ch7: level=%h sticky=%h, required 89 08", bus.btn_level, bus.btn_sticky);
    end
  endtask

  // Reset arrives while channel 5 is mid-count and channels 0/3/7 are held.
  task automatic test_reset_mid_count();
    bus.btn_raw[5] = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_sticky} !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_async: level=%h press=%h release=%h sticky=%h, required all 00",
               bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_sticky);
    end
    bus.btn_raw = 8'hFF;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_sticky} !== 32'h0) begin
        fails++;
        $display("FAIL reset_mid_after cycle %0d: level=%h press=%h release=%h sticky=%h, required all 00",
                 k, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_sticky);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_release();
    test_sticky_clear();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditioning stage directly upstream of the memory-mapped button read port. It feeds the eight bomb-module button lines: morse_left, morse_right, morse_tx, keypad_TL, keypad_TR, keypad_LL, keypad_LR and button_bigButton.
- Each raw pin input is synchronised, debounced with a per-channel stability counter, and optionally inverted.
- Outputs per channel: a clean level, one-cycle press/release pulses, and sticky press flags that the CPU-side logic clears explicitly.

Parameters:
- N, 8, number of button channels.
- CNT_WIDTH, 16, width of each per-channel debounce counter.
- DEBOUNCE_CYCLES, 50000, consecutive cycles a changed input must hold before it is accepted (1 ms at 50 MHz). Valid range is 2 to 2^CNT_WIDTH-1.
- ACTIVE_LOW, 8'hFF, per-channel mask. Bit=1 means the pin reads 0 when pressed; the channel is inverted internally.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  N  raw asynchronous button pins. Bit 7 = morse_left … bit 0 = button_bigButton.
- clr_sticky  in  N  per-bit clear strobe for btn_sticky, sampled on clk.
- btn_level  out  N  debounced level; 1 = pressed, after polarity correction.
- btn_press  out  N  one-cycle pulse when btn_level goes 0→1.
- btn_release  out  N  one-cycle pulse when btn_level goes 1→0.
- btn_sticky  out  N  set on press, held until cleared.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Both synchroniser FFs of channel i load ACTIVE_LOW[i], the idle pin value.
  - All counters load 0.
  - btn_level, btn_press, btn_release and btn_sticky load 0.
  - Release of reset must not produce a press pulse while pins sit at idle.
- Synchroniser: two-FF chain per channel. s_i = sync2[i] XOR ACTIVE_LOW[i].
- Debounce, per channel, at each clk edge:
  - If s_i == btn_level[i]: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: btn_level[i] <= s_i and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
- Latency: a clean pin transition before edge 0 first reaches sync2 at edge 2. btn_level flips at edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any return of s_i to btn_level before the count completes restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- Pulses:
  - btn_press[i] and btn_release[i] are registered. Each is high for exactly the one cycle following the edge at which btn_level[i] flips.
  - The two are never high together on the same channel.
- Sticky flags, per channel:
  - Set condition: the same edge at which btn_level[i] flips 0→1 (concurrent with btn_press[i] being registered).
  - Clear condition: clr_sticky[i]=1 at an edge.
  - Simultaneous set and clear on one channel: set wins, and the flag stays 1.
  - Clear with no set: flag goes to 0 at that edge.
  - clr_sticky on other bits does not affect channel i.
- Channels are fully independent. Simultaneous transitions on several channels are each handled on their own schedule.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-count: counters, levels and flags clear immediately. No pulse is emitted on reset assertion or deassertion.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset with btn_raw=8'hFF, ACTIVE_LOW=8'hFF, release rst_n, hold 20 cycles -> btn_level=0, btn_press=0, btn_sticky=0 throughout.
- Drive btn_raw[0] 1→0 before edge 0 and hold -> btn_level[0]=1 after edge 6; btn_press[0]=1 for exactly cycle 6–7; btn_sticky[0]=1 thereafter.
- Glitch: btn_raw[3] low for 3 cycles, then back high -> btn_level[3] stays 0, no pulses. Then low for 4+ cycles -> accepted at 6 edges after the low edge.
- Bounce: btn_raw[7] toggles 0,1,0,1 every 2 cycles, then holds 0 -> exactly one btn_press[7], 6 edges after the final transition.
- Release of held channel 0 -> btn_release[0] one-cycle pulse, 6 edges after the pin returns high; btn_sticky[0] remains 1.
- Sticky clear: assert clr_sticky=8'h01 on the same edge as a new channel-0 press, which keeps the flag at 1. Then assert clr_sticky=8'h01 alone, which clears it to 0, with other bits unchanged. Also assert rst_n low mid-count on channel 5 -> all outputs 0 and no pulse afterwards.
